// File: rtl/int_div_seq.sv
// int_div_seq: parametrised multi-cycle radix-2 restoring integer divider
// with signed/unsigned mode, valid/ready handshakes and saturated flag results.
module int_div_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             div_zero,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX = ~MIN;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_n;
  logic sgn, a_neg, b_neg, dz_int, ov_int;
  logic an_in, bn_in, accept, last, ge;
  logic [WIDTH-1:0] dq, b_mag, prem, q_fix, r_fix;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH+1:0] diff;
  assign in_ready = (state == IDLE) && rst;
  assign out_valid = (state == DONE);
  assign accept = in_valid && in_ready;
  assign an_in = in_signed & a[WIDTH-1];
  assign bn_in = in_signed & b[WIDTH-1];
  assign last = (cnt == CW'(WIDTH-1));
  always_comb begin
    state_n = (state == IDLE && accept) ? CALC :
              (state == CALC && last) ? FIX :
              (state == FIX) ? DONE :
              (state == DONE && out_ready) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else state <= state_n;
  end
  // dq starts as the dividend magnitude and fills with quotient bits from the right
  always_comb begin
    rem_sh = {prem, dq[WIDTH-1]};
    diff = {1'b0, rem_sh} - {2'b0, b_mag};
    ge = !diff[WIDTH+1];
    q_fix = dz_int ? (sgn ? (a_neg ? MIN : MAX) : '1) :
            ov_int ? MAX : ((a_neg ^ b_neg) ? -dq : dq);
    // with b == 0 every trial succeeds, so prem ends up equal to |a|
    r_fix = ov_int ? '0 : (a_neg ? -prem : prem);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      quot <= '0;
      rem <= '0;
      div_zero <= 1'b0;
      ovf <= 1'b0;
    end else begin
      if (state == IDLE && accept) begin
        sgn <= in_signed;
        a_neg <= an_in;
        b_neg <= bn_in;
        dq <= an_in ? -a : a;
        b_mag <= bn_in ? -b : b;
        dz_int <= (b == '0);
        ov_int <= in_signed && (a == MIN) && (b == '1);
        prem <= '0;
        cnt <= '0;
      end
      if (state == CALC) begin
        prem <= ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        dq <= {dq[WIDTH-2:0], ge};
        cnt <= cnt + 1'b1;
      end
      if (state == FIX) begin
        quot <= q_fix;
        rem <= r_fix;
        div_zero <= dz_int;
        ovf <= ov_int;
      end
    end
  end
endmodule

// File: tb/tb_int_div_seq.sv
// tb_int_div_seq: directed self-checking bench for int_div_seq at WIDTH=16.
module tb_int_div_seq;
  logic clk = 0, rst = 0, in_valid = 0, in_signed = 0, out_ready = 0;
  logic [15:0] a = 0, b = 0;
  logic in_ready, out_valid, div_zero, ovf;
  logic [15:0] quot, rem;
  int checks = 0, passed = 0;

  int_div_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_signed(in_signed), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .quot(quot), .rem(rem), .div_zero(div_zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic op(input string tag, input logic sg, input logic [15:0] av, input logic [15:0] bv,
                    input logic [15:0] eq, input logic [15:0] er, input logic edz, input logic eov,
                    input int hold);
    int n;
    logic [15:0] q0, r0;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " in_ready"}, in_ready, 1);
    in_valid = 1;
    in_signed = sg;
    a = av;
    b = bv;
    @(posedge clk);
    #1;
    in_valid = 0;
    in_signed = ~sg;
    a = 16'h1234;
    b = 16'h0000;
    n = 1;
    @(negedge clk);
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " latency"}, n, 18);
    chk({tag, " quot"}, quot, eq);
    chk({tag, " rem"}, rem, er);
    chk({tag, " div_zero"}, div_zero, edz);
    chk({tag, " ovf"}, ovf, eov);
    q0 = quot;
    r0 = rem;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, " bp out_valid"}, out_valid, 1);
      chk({tag, " bp in_ready"}, in_ready, 0);
      chk({tag, " bp stable"}, {quot, rem}, {q0, r0});
    end
    out_ready = 1;
    @(posedge clk);
    #1;
    out_ready = 0;
    @(negedge clk);
    chk({tag, " in_ready after"}, in_ready, 1);
    chk({tag, " out_valid after"}, out_valid, 0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("reset out_valid", out_valid, 0);
    chk("reset in_ready", in_ready, 0);
    chk("reset outputs", {quot, rem, div_zero, ovf}, 0);
    rst = 1;
    @(negedge clk);
    chk("release in_ready", in_ready, 1);

    op("s100/7", 1, 16'd100, 16'd7, 16'd14, 16'd2, 0, 0, 0);
    op("s-100/7", 1, 16'hFF9C, 16'd7, 16'hFFF2, 16'hFFFE, 0, 0, 0);
    op("u0xFF9C/7", 0, 16'hFF9C, 16'd7, 16'h2484, 16'h0000, 0, 0, 0);
    op("s ovf", 1, 16'h8000, 16'hFFFF, 16'h7FFF, 16'h0000, 0, 1, 0);
    op("u 8000/FFFF", 0, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 0, 0, 0);
    op("s5/0", 1, 16'd5, 16'd0, 16'h7FFF, 16'd5, 1, 0, 0);
    op("s-5/0", 1, 16'hFFFB, 16'd0, 16'h8000, 16'hFFFB, 1, 0, 0);
    op("u5/0", 0, 16'd5, 16'd0, 16'hFFFF, 16'd5, 1, 0, 0);
    op("u1000/10 bp", 0, 16'd1000, 16'd10, 16'd100, 16'd0, 0, 0, 6);
    op("s200/-3", 1, 16'd200, 16'hFFFD, 16'hFFBE, 16'd2, 0, 0, 0);

    in_valid = 1;
    in_signed = 1;
    a = 16'd77;
    b = 16'd5;
    @(posedge clk);
    #1;
    in_valid = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    @(negedge clk);
    chk("midreset out_valid", out_valid, 0);
    chk("midreset outputs", {quot, rem, div_zero, ovf}, 0);
    chk("midreset in_ready", in_ready, 0);
    rst = 1;
    @(negedge clk);
    chk("midreset release in_ready", in_ready, 1);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    chk("midreset no stale result", n, 0);
    chk("midreset idle in_ready", in_ready, 1);

    op("u65535/255", 0, 16'hFFFF, 16'd255, 16'd257, 16'd0, 0, 0, 0);
    op("s-7/-2", 1, 16'hFFF9, 16'hFFFE, 16'd3, 16'hFFFF, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/int_div_seq.md
Name: int_div_seq

Overview:
Parametrised multi-cycle radix-2 restoring integer divider, the successor to the fixed 16-bit divider.
- Generalises to WIDTH bits with per-operation signed/unsigned mode.
- Uses a full valid/ready handshake on input and output, with output backpressure.
- Flags divide-by-zero and signed overflow, with defined saturated results.
- Sits beside the combinational add/sub/mul units as the long-latency arithmetic resource.

Parameters:
- WIDTH, 16, operand/quotient/remainder width in bits; legal range 2..64.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-low reset; 0 = reset
- in_valid  input  1  operands and mode are presented
- in_ready  output  1  divider can accept an operation
- in_signed  input  1  1 = two's-complement operation, 0 = unsigned
- a  input  WIDTH  dividend
- b  input  WIDTH  divisor
- out_valid  output  1  result is valid
- out_ready  input  1  consumer accepts the result
- quot  output  WIDTH  quotient
- rem  output  WIDTH  remainder
- div_zero  output  1  b was 0
- ovf  output  1  signed overflow: a = MIN, b = -1

Behaviour:

Clock and reset
- Single clock domain.
- rst is synchronous and active-low, sampled on the rising edge of clk.
- rst = 0 at an edge forces state IDLE and clears quot, rem, div_zero, ovf and out_valid to 0.
- in_ready = 0 while rst = 0; in_ready = 1 from the first cycle after rst is released.
- Reset mid-operation abandons the operation; no result is ever presented for it.

States: IDLE, CALC, FIX, DONE.
- in_ready = (state == IDLE). out_valid = (state == DONE).

IDLE
- An accept is in_valid && in_ready at a rising edge; that cycle is "cycle 0".
- On accept, register the following:
  - in_signed into sgn.
  - Magnitudes |a| and |b| as WIDTH-bit unsigned values. Negation applies only when sgn = 1 and the MSB is set; |MIN| = 2^(WIDTH-1) is representable.
  - The dividend sign and divisor sign.
  - div_zero_int = (b == 0).
  - ovf_int = sgn && a == MIN && b == all-ones.
- Clear the partial remainder and the iteration counter, then go to CALC.
- Operand inputs are ignored in all states other than IDLE.

CALC: cycles 1..WIDTH, one quotient bit per cycle, MSB first.
- Shift the next dividend bit into the partial remainder.
- Perform a (WIDTH+1)-bit trial subtract of the divisor.
- If the result is non-negative, keep the difference and set the quotient bit to 1; otherwise restore and set it to 0.
- The counter runs 0..WIDTH-1. After WIDTH iterations, go to FIX.
- Latency is fixed for every operand value, including b = 0.

FIX: cycle WIDTH+1. Load quot and rem using the first matching rule:
- div_zero_int:
  - rem = a.
  - Unsigned: quot = all-ones.
  - Signed: quot = MAX (0111..1) if a >= 0, otherwise MIN (1000..0).
- ovf_int: quot = MAX, rem = 0.
- Otherwise: quotient truncates toward zero.
  - quot is negated if the dividend sign XOR the divisor sign is 1 (signed mode only).
  - rem is negated if the dividend sign is 1 (signed mode only); rem therefore takes the dividend's sign.
- Copy div_zero_int and ovf_int to div_zero and ovf. Go to DONE.

DONE: out_valid = 1 from cycle WIDTH+2.
- quot, rem, div_zero and ovf are held stable until the handshake completes.
- A handshake is out_valid && out_ready at an edge; on that edge go to IDLE, so in_ready = 1 in the next cycle.
- Minimum issue interval is WIDTH+3 cycles.
- Outputs keep their last value in IDLE. Consumers must only sample them while out_valid = 1.

Invariant: for non-flagged results, a == quot*b + rem, with |rem| < |b| (interpreted in the selected mode).

Test Plan:
All scenarios use WIDTH=16.
1. Signed 100 / 7 -> quot=14, rem=2, flags 0; out_valid first high exactly 18 cycles after the accept cycle.
2. Signed -100 (0xFF9C) / 7 -> quot=0xFFF2 (-14), rem=0xFFFE (-2). Same bits as unsigned, 0xFF9C / 7 -> quot=9348 (0x2484), rem=0.
3. Signed 0x8000 / 0xFFFF -> quot=0x7FFF, rem=0, ovf=1, div_zero=0. Unsigned 0x8000 / 0xFFFF -> quot=0, rem=0x8000, ovf=0.
4. b=0: signed 5 -> quot=0x7FFF, rem=5, div_zero=1. Signed -5 -> quot=0x8000, rem=0xFFFB. Unsigned 5 -> quot=0xFFFF. Latency is still 18 cycles.
5. Backpressure: hold out_ready=0 for 6 cycles after out_valid rises -> outputs stable and in_ready=0 throughout. Pulse out_ready -> in_ready=1 next cycle; a back-to-back second operation (200 / -3 -> quot=0xFFBE, rem=2) completes correctly.
6. Assert rst=0 during CALC cycle 5 -> next cycle out_valid=0, quot=rem=0, flags 0; in_ready=1 the cycle after rst returns to 1; no stale result ever appears.
